// File: rtl/bsg_cache_stream_prefetch_inject.sv
// Stream-trained prefetch injector placed directly in front of bsg_cache.
// Learns sequential block streams from accepted core loads, slips LW prefetches
// into idle cache-input cycles, and absorbs their responses so the core only
// ever sees its own responses, in order.
module bsg_cache_stream_prefetch_inject #(
  parameter int unsigned addr_width_p          = 30,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 8,
  parameter int unsigned streams_p             = 4,
  parameter int unsigned prefetch_distance_p   = 2,
  parameter int unsigned track_els_p           = 8,
  localparam int unsigned mask_width_lp   = data_width_p / 8,
  localparam int unsigned opcode_width_lp = 6,
  localparam int unsigned pkt_width_lp    = opcode_width_lp + addr_width_p + data_width_p + mask_width_lp
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,

  input  logic [pkt_width_lp-1:0] core_pkt_i,
  input  logic                    core_v_i,
  output logic                    core_yumi_o,

  output logic [data_width_p-1:0] core_data_o,
  output logic                    core_v_o,
  input  logic                    core_yumi_i,

  output logic [pkt_width_lp-1:0] cache_pkt_o,
  output logic                    cache_v_o,
  input  logic                    cache_yumi_i,

  input  logic [data_width_p-1:0] cache_data_i,
  input  logic                    cache_v_i,
  output logic                    cache_yumi_o
);

  localparam int unsigned block_bytes_lp  = block_size_in_words_p * data_width_p / 8;
  localparam int unsigned offset_width_lp = $clog2(block_bytes_lp);
  localparam int unsigned idx_width_lp    = addr_width_p - offset_width_lp;
  localparam int unsigned addr_lsb_lp     = data_width_p + mask_width_lp;
  localparam int unsigned rr_width_lp     = (streams_p > 1) ? $clog2(streams_p) : 1;
  localparam int unsigned ptr_width_lp    = (track_els_p > 1) ? $clog2(track_els_p) : 1;
  localparam int unsigned count_width_lp  = $clog2(track_els_p + 1);
  localparam logic [opcode_width_lp-1:0] opcode_lw_lp = 6'b000010;

  // Outputs are held quiet until one full cycle after reset has been released.
  logic init_done;

  // Stream table, pending prefetch and round-robin victim pointer.
  logic [streams_p-1:0]    stream_v;
  logic [idx_width_lp-1:0] stream_idx [streams_p];
  logic [rr_width_lp-1:0]  rr_ptr;
  logic                    pending_v;
  logic [idx_width_lp-1:0] pending_idx;

  // Response-steering FIFO: one bit per outstanding request, 1 = prefetch.
  logic [track_els_p-1:0]    fifo_mem;
  logic [ptr_width_lp-1:0]   wr_ptr, rd_ptr;
  logic [count_width_lp-1:0] fifo_count;
  logic                      fifo_full, fifo_empty, head_pf;

  logic [idx_width_lp-1:0] core_idx, prev_idx, target_idx;
  logic                    is_load, train;
  logic                    hit_found, hit_seq;
  logic [rr_width_lp-1:0]  hit_sel;
  logic                    accept, pf_issue, pop;
  logic [pkt_width_lp-1:0] pf_pkt;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(track_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  function automatic logic [rr_width_lp-1:0] rr_inc(input logic [rr_width_lp-1:0] p);
    return (p == rr_width_lp'(streams_p - 1)) ? '0 : p + rr_width_lp'(1);
  endfunction

  // Block index of the incoming core packet; loads are opcodes 0..7.
  assign core_idx   = core_pkt_i[addr_lsb_lp+addr_width_p-1 : addr_lsb_lp+offset_width_lp];
  assign is_load    = (core_pkt_i[pkt_width_lp-1 -: 3] == 3'b000);
  assign prev_idx   = core_idx - idx_width_lp'(1);
  assign target_idx = core_idx + idx_width_lp'(prefetch_distance_p);

  assign fifo_full  = (fifo_count == count_width_lp'(track_els_p));
  assign fifo_empty = (fifo_count == '0);
  assign head_pf    = fifo_mem[rd_ptr];

  assign pf_pkt = {opcode_lw_lp, pending_idx, offset_width_lp'(0),
                   data_width_p'(0), {mask_width_lp{1'b1}}};

  // Request side: core has priority, prefetch fills idle slots.
  assign cache_v_o   = init_done & (core_v_i | pending_v) & ~fifo_full;
  assign cache_pkt_o = core_v_i ? core_pkt_i : pf_pkt;
  assign accept      = cache_v_o & cache_yumi_i;
  assign core_yumi_o = accept & core_v_i;
  assign pf_issue    = accept & ~core_v_i;
  assign train       = core_yumi_o & is_load & en_i;

  // Response side: forward core responses, silently absorb prefetch ones.
  assign core_data_o  = cache_data_i;
  assign core_v_o     = init_done & ~fifo_empty & ~head_pf & cache_v_i;
  assign cache_yumi_o = init_done & ~fifo_empty & cache_v_i & (head_pf | core_yumi_i);
  assign pop          = cache_v_i & cache_yumi_o;

  // Find the lowest-indexed entry that is either one block behind or at this block.
  always_comb begin
    hit_found = 1'b0;
    hit_seq   = 1'b0;
    hit_sel   = '0;
    for (int i = 0; i < streams_p; i++) begin
      if (!hit_found && stream_v[i] &&
          ((stream_idx[i] == prev_idx) || (stream_idx[i] == core_idx))) begin
        hit_found = 1'b1;
        hit_seq   = (stream_idx[i] == prev_idx);
        hit_sel   = rr_width_lp'(i);
      end
    end
  end

  // Post-reset quiet cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) init_done <= 1'b0;
    else            init_done <= 1'b1;
  end

  // Stream-table training and round-robin allocation.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stream_v <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < streams_p; i++) stream_idx[i] <= '0;
    end else if (train) begin
      if (hit_found) begin
        if (hit_seq) stream_idx[hit_sel] <= core_idx;
      end else begin
        stream_idx[rr_ptr] <= core_idx;
        stream_v[rr_ptr]   <= 1'b1;
        rr_ptr             <= rr_inc(rr_ptr);
      end
    end
  end

  // Pending prefetch: set by a sequential hit, cleared on issue or when disabled.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pending_v   <= 1'b0;
      pending_idx <= '0;
    end else if (!en_i) begin
      pending_v <= 1'b0;
    end else if (train && hit_found && hit_seq) begin
      pending_v   <= 1'b1;
      pending_idx <= target_idx;
    end else if (pf_issue) begin
      pending_v <= 1'b0;
    end
  end

  // Steering FIFO push/pop bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fifo_mem   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= ~core_v_i;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + count_width_lp'(1);
        2'b01:   fifo_count <= fifo_count - count_width_lp'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A cache response with nothing outstanding means the cache and this block disagree.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && init_done) begin
      assert (!(cache_v_i && fifo_empty))
        else $fatal(1, "cache response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_bsg_cache_stream_prefetch_inject.sv
// Scoreboard bench: the bench plays core and cache; expected core data and
// expected prefetch addresses are queued when stimulus is driven.
module tb_bsg_cache_stream_prefetch_inject;

  localparam int unsigned PW       = 6 + 30 + 32 + 4;
  localparam int unsigned ADDR_LSB = 36;
  localparam logic [5:0]  OP_LW    = 6'b000010;
  localparam logic [5:0]  OP_SW    = 6'b001010;

  logic          clk_i = 1'b0;
  logic          reset_n_i, en_i;
  logic [PW-1:0] core_pkt_i;
  logic          core_v_i, core_yumi_o;
  logic [31:0]   core_data_o;
  logic          core_v_o, core_yumi_i;
  logic [PW-1:0] cache_pkt_o;
  logic          cache_v_o, cache_yumi_i;
  logic [31:0]   cache_data_i;
  logic          cache_v_i, cache_yumi_o;

  logic accept_en = 1'b0;
  logic resp_en   = 1'b1;
  logic bp_en     = 1'b0;

  logic [31:0] exp_q[$];
  logic [29:0] pf_exp_q[$];
  logic [31:0] rsp_data_q[$];
  logic        rsp_pf_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_core_rsp = 0;
  int n_pf = 0;

  bsg_cache_stream_prefetch_inject dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i),
    .core_pkt_i(core_pkt_i), .core_v_i(core_v_i), .core_yumi_o(core_yumi_o),
    .core_data_o(core_data_o), .core_v_o(core_v_o), .core_yumi_i(core_yumi_i),
    .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_yumi_i(cache_yumi_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o)
  );

  always #5 clk_i = ~clk_i;

  // Cache accepts whatever is offered while accept_en is high.
  assign cache_yumi_i = accept_en & cache_v_o;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [5:0] op, input logic [29:0] a);
    return {op, a, 32'h0, 4'hF};
  endfunction

  function automatic logic [31:0] rdata(input logic [29:0] a);
    return {2'b00, a} ^ 32'hA5C3_0F96;
  endfunction

  // Cache model: in-order responses one cycle after acceptance; random core backpressure.
  always @(posedge clk_i) begin
    #1;
    if (!reset_n_i) begin
      cache_v_i    = 1'b0;
      cache_data_i = '0;
    end else begin
      cache_v_i    = resp_en && (rsp_data_q.size() != 0);
      cache_data_i = (rsp_data_q.size() != 0) ? rsp_data_q[0] : 32'h0;
    end
    core_yumi_i = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: observes the handshakes that complete at the coming rising edge.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (cache_v_i && rsp_pf_q.size() != 0) begin
        if (rsp_pf_q[0]) begin
          chk("pf_absorb", PW'({core_v_o, cache_yumi_o}), PW'(2'b01));
        end else begin
          chk("core_rsp_v", PW'(core_v_o), PW'(1));
          chk("rsp_yumi", PW'(cache_yumi_o), PW'(core_yumi_i));
          if (core_v_o && core_yumi_i) begin
            n_core_rsp++;
            if (exp_q.size() == 0) chk("spurious_rsp", PW'(core_data_o), PW'(0));
            else                   chk("core_data", PW'(core_data_o), PW'(exp_q.pop_front()));
          end
        end
        if (cache_yumi_o) begin
          void'(rsp_data_q.pop_front());
          void'(rsp_pf_q.pop_front());
        end
      end else begin
        chk("idle_rsp", PW'({core_v_o, cache_yumi_o}), PW'(0));
      end

      if (cache_v_o && cache_yumi_i) begin
        if (core_v_i) begin
          chk("pass_pkt", cache_pkt_o, core_pkt_i);
          chk("core_yumi", PW'(core_yumi_o), PW'(1));
          exp_q.push_back(rdata(core_pkt_i[ADDR_LSB +: 30]));
          rsp_pf_q.push_back(1'b0);
        end else begin
          n_pf++;
          if (pf_exp_q.size() == 0) chk("unexpected_pf", cache_pkt_o, PW'(0));
          else                      chk("pf_pkt", cache_pkt_o, mk_pkt(OP_LW, pf_exp_q.pop_front()));
          rsp_pf_q.push_back(1'b1);
        end
        rsp_data_q.push_back(rdata(cache_pkt_o[ADDR_LSB +: 30]));
      end else begin
        chk("core_yumi_idle", PW'(core_yumi_o), PW'(0));
      end
    end
  end

  task automatic wait_accept(output int waits);
    waits = 0;
    forever begin
      @(negedge clk_i);
      if (core_yumi_o) break;
      waits++;
      if (waits > 60) begin
        chk("accept_timeout", PW'(waits), PW'(0));
        break;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic load(input logic [5:0] op, input logic [29:0] a, output int waits);
    core_v_i   = 1'b1;
    core_pkt_i = mk_pkt(op, a);
    wait_accept(waits);
  endtask

  task automatic idle(input int n);
    core_v_i   = 1'b0;
    core_pkt_i = '0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain_and_reset();
    core_v_i = 1'b0;
    for (int c = 0; c < 200 && (rsp_data_q.size() != 0 || exp_q.size() != 0); c++) @(posedge clk_i);
    chk("drain", PW'(rsp_data_q.size() + exp_q.size()), PW'(0));
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    int w;
    int base;
    reset_n_i    = 1'b0;
    en_i         = 1'b1;
    core_v_i     = 1'b1;
    core_pkt_i   = mk_pkt(OP_LW, 30'h100);
    core_yumi_i  = 1'b1;
    cache_v_i    = 1'b0;
    cache_data_i = '0;

    // Reset held with a core packet offered: everything stays quiet.
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_core_yumi", PW'(core_yumi_o), PW'(0));
    chk("rst_core_v", PW'(core_v_o), PW'(0));
    chk("rst_cache_v", PW'(cache_v_o), PW'(0));
    chk("rst_cache_yumi", PW'(cache_yumi_o), PW'(0));
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    accept_en = 1'b1;
    @(negedge clk_i);
    chk("rst1_cache_v", PW'(cache_v_o), PW'(0));
    chk("rst1_core_yumi", PW'(core_yumi_o), PW'(0));
    wait_accept(w);
    chk("post_rst_wait", PW'(w), PW'(0));
    idle(4);

    // Sequential loads with idle gaps: block 1 -> prefetch block 3, block 2 -> block 4.
    base = n_core_rsp;
    load(OP_LW, 30'h000, w); idle(3);
    load(OP_LW, 30'h020, w); pf_exp_q.push_back(30'h060); idle(3);
    load(OP_LW, 30'h040, w); pf_exp_q.push_back(30'h080); idle(4);
    chk("seq_pf_left", PW'(pf_exp_q.size()), PW'(0));
    chk("seq_rsp_count", PW'(n_core_rsp - base), PW'(3));

    // Back-to-back stream: prefetch only once the core goes idle, core never stalled.
    for (int i = 0; i < 20; i++) begin
      load(OP_LW, 30'h2000 + 30'(i * 32), w);
      chk("no_stall", PW'(w), PW'(0));
    end
    pf_exp_q.push_back(30'h22A0);
    idle(4);
    chk("hold_pf_left", PW'(pf_exp_q.size()), PW'(0));

    // Responses withheld: 8 outstanding fills the tracker, the 9th waits.
    resp_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      load(OP_LW, 30'(k) << 20, w);
      chk("fill", PW'(w), PW'(0));
    end
    core_v_i   = 1'b1;
    core_pkt_i = mk_pkt(OP_LW, 30'(9) << 20);
    repeat (4) begin
      @(negedge clk_i);
      chk("full_stall", PW'(core_yumi_o), PW'(0));
      chk("full_cache_v", PW'(cache_v_o), PW'(0));
    end
    @(posedge clk_i); #1;
    resp_en = 1'b1;
    wait_accept(w);
    chk("full_release", PW'(w < 10), PW'(1));
    idle(12);

    // Round-robin eviction: 0x1000 replaces entry 0, so 0x020 does not prefetch.
    drain_and_reset();
    load(OP_LW, 30'h0000, w); idle(2);
    load(OP_LW, 30'h0400, w); idle(2);
    load(OP_LW, 30'h0800, w); idle(2);
    load(OP_LW, 30'h0C00, w); idle(2);
    load(OP_LW, 30'h1000, w); idle(2);
    load(OP_LW, 30'h0020, w); idle(3);
    load(OP_LW, 30'h1020, w); pf_exp_q.push_back(30'h1060); idle(3);
    load(OP_LW, 30'h0C20, w); pf_exp_q.push_back(30'h0C60); idle(3);
    chk("evict_pf_left", PW'(pf_exp_q.size()), PW'(0));

    // Target index wraps at the top of the address space.
    drain_and_reset();
    load(OP_LW, 30'h3FFFFFC0, w); idle(2);
    load(OP_LW, 30'h3FFFFFE0, w); pf_exp_q.push_back(30'h00000020); idle(3);
    chk("wrap_pf_left", PW'(pf_exp_q.size()), PW'(0));

    // Disabled: no training, no prefetch; with core backpressure on responses.
    bp_en = 1'b1;
    en_i  = 1'b0;
    load(OP_LW, 30'h5000, w); idle(3);
    load(OP_LW, 30'h5020, w); idle(3);
    load(OP_LW, 30'h5040, w); idle(3);
    // Stores never train.
    en_i = 1'b1;
    load(OP_SW, 30'h6000, w); idle(2);
    load(OP_LW, 30'h6020, w); idle(3);
    load(OP_LW, 30'h6040, w); pf_exp_q.push_back(30'h6080); idle(3);
    // Pending set, then disabled while the core is busy: pending is dropped.
    load(OP_LW, 30'h7000, w);
    load(OP_LW, 30'h7020, w);
    en_i = 1'b0;
    load(OP_LW, 30'h9000, w);
    idle(20);
    bp_en = 1'b0;
    idle(10);

    chk("final_pf_left", PW'(pf_exp_q.size()), PW'(0));
    chk("final_exp_left", PW'(exp_q.size()), PW'(0));
    chk("final_rsp_left", PW'(rsp_data_q.size()), PW'(0));
    chk("pf_total", PW'(n_pf), PW'(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
